// File: rtl/crosslink_pkt_parser.sv
// DSI packet parser for the CrossLink HS byte stream.
// Frames header, payload and CRC per packet, with lock-aware abort handling.
module crosslink_pkt_parser #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             hdr_valid,
    output logic [7:0]       hdr_di,
    output logic [15:0]      hdr_wc,
    output logic [7:0]       hdr_ecc,
    output logic             hdr_long,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pl_last,
    output logic             pkt_done,
    output logic             crc_ok,
    output logic             err_trunc,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CRC,
        S_SKIP
    } state_t;

    state_t          state_q;
    logic            lock_s1_q;
    logic            lock_s_q;
    logic            rxv_q;
    logic [1:0]      hcnt_q;
    logic            ccnt_q;
    logic [7:0]      di_sh_q;
    logic [15:0]     wc_sh_q;
    logic [15:0]     pcnt_q;
    logic [15:0]     crc_q;
    logic [7:0]      crc_lo_q;
    logic            hdr_valid_q;
    logic [7:0]      hdr_di_q;
    logic [15:0]     hdr_wc_q;
    logic [7:0]      hdr_ecc_q;
    logic            hdr_long_q;
    logic [7:0]      pl_data_q;
    logic            pl_valid_q;
    logic            pl_last_q;
    logic            pkt_done_q;
    logic            crc_ok_q;
    logic            err_trunc_q;
    logic [CNT_W-1:0] pkt_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic            in_pkt;
    logic            long_d;
    logic            crc_match;
    logic [15:0]     crc_d;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // HDR with hcnt=0 sits between packets, so nothing is lost there.
    always_comb begin
        in_pkt    = ((state_q == S_HDR) && (hcnt_q != 2'd0)) ||
                    (state_q == S_PAY) || (state_q == S_CRC);
        long_d    = di_sh_q[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
        crc_d     = crc_step(crc_q, rx_data);
        crc_match = ({rx_data, crc_lo_q} == crc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lock_s1_q   <= 1'b0;
            lock_s_q    <= 1'b0;
            rxv_q       <= 1'b0;
            hcnt_q      <= 2'd0;
            ccnt_q      <= 1'b0;
            di_sh_q     <= 8'h00;
            wc_sh_q     <= 16'h0000;
            pcnt_q      <= 16'h0000;
            crc_q       <= 16'hFFFF;
            crc_lo_q    <= 8'h00;
            hdr_valid_q <= 1'b0;
            hdr_di_q    <= 8'h00;
            hdr_wc_q    <= 16'h0000;
            hdr_ecc_q   <= 8'h00;
            hdr_long_q  <= 1'b0;
            pl_data_q   <= 8'h00;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            err_trunc_q <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            lock_s1_q   <= pll_lock;
            lock_s_q    <= lock_s1_q;
            rxv_q       <= rx_valid;
            hdr_valid_q <= 1'b0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_trunc_q <= 1'b0;
            if (!lock_s_q || !rx_valid) begin
                state_q <= S_IDLE;
                if (in_pkt) begin
                    err_trunc_q <= 1'b1;
                    err_count_q <= sat_inc(err_count_q);
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        // valid already high last cycle: joined mid-burst
                        if (rxv_q) begin
                            state_q <= S_SKIP;
                        end else begin
                            di_sh_q <= rx_data;
                            hcnt_q  <= 2'd1;
                            state_q <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        hcnt_q <= hcnt_q + 2'd1;
                        unique case (hcnt_q)
                            2'd0: di_sh_q <= rx_data;
                            2'd1: wc_sh_q[7:0] <= rx_data;
                            2'd2: wc_sh_q[15:8] <= rx_data;
                            default: begin
                                hdr_valid_q <= 1'b1;
                                hdr_di_q    <= di_sh_q;
                                hdr_wc_q    <= wc_sh_q;
                                hdr_ecc_q   <= rx_data;
                                hdr_long_q  <= long_d;
                                crc_q       <= 16'hFFFF;
                                pcnt_q      <= wc_sh_q;
                                ccnt_q      <= 1'b0;
                                if (long_d && (wc_sh_q != 16'h0000)) begin
                                    state_q <= S_PAY;
                                end else if (long_d) begin
                                    state_q <= S_CRC;
                                end else begin
                                    pkt_done_q  <= 1'b1;
                                    crc_ok_q    <= 1'b1;
                                    pkt_count_q <= sat_inc(pkt_count_q);
                                end
                            end
                        endcase
                    end
                    S_PAY: begin
                        pl_data_q  <= rx_data;
                        pl_valid_q <= 1'b1;
                        crc_q      <= crc_d;
                        pcnt_q     <= pcnt_q - 16'd1;
                        if (pcnt_q == 16'd1) begin
                            pl_last_q <= 1'b1;
                            state_q   <= S_CRC;
                        end
                    end
                    S_CRC: begin
                        if (!ccnt_q) begin
                            crc_lo_q <= rx_data;
                            ccnt_q   <= 1'b1;
                        end else begin
                            pkt_done_q  <= 1'b1;
                            crc_ok_q    <= crc_match;
                            pkt_count_q <= sat_inc(pkt_count_q);
                            if (!crc_match) begin
                                err_count_q <= sat_inc(err_count_q);
                            end
                            hcnt_q  <= 2'd0;
                            state_q <= S_HDR;
                        end
                    end
                    S_SKIP: state_q <= S_SKIP;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign hdr_di    = hdr_di_q;
    assign hdr_wc    = hdr_wc_q;
    assign hdr_ecc   = hdr_ecc_q;
    assign hdr_long  = hdr_long_q;
    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pl_last   = pl_last_q;
    assign pkt_done  = pkt_done_q;
    assign crc_ok    = crc_ok_q;
    assign err_trunc = err_trunc_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_crosslink_pkt_parser.sv
// Scoreboard bench for crosslink_pkt_parser.
// Expected events are queued as bursts are built and popped by a monitor.
module tb_crosslink_pkt_parser;

    localparam int CNT_W = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc;
        logic        lng;
    } hdr_t;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } pl_t;

    typedef struct packed {
        logic ok;
        logic with_hdr;
    } done_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_lock;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             hdr_valid;
    logic [7:0]       hdr_di;
    logic [15:0]      hdr_wc;
    logic [7:0]       hdr_ecc;
    logic             hdr_long;
    logic [7:0]       pl_data;
    logic             pl_valid;
    logic             pl_last;
    logic             pkt_done;
    logic             crc_ok;
    logic             err_trunc;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    hdr_t  hdr_exp[$];
    pl_t   pl_exp[$];
    done_t done_exp[$];
    int    trunc_exp;
    bq_t   burst;
    logic [CNT_W-1:0] exp_pkt;
    logic [CNT_W-1:0] exp_err;
    int    checks;
    int    errors;

    crosslink_pkt_parser #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .hdr_valid (hdr_valid),
        .hdr_di    (hdr_di),
        .hdr_wc    (hdr_wc),
        .hdr_ecc   (hdr_ecc),
        .hdr_long  (hdr_long),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_last   (pl_last),
        .pkt_done  (pkt_done),
        .crc_ok    (crc_ok),
        .err_trunc (err_trunc),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // bit-serial CRC-16 reference, reflected poly 0x8408
    function automatic logic [15:0] crc_model(input bq_t d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ d[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    function automatic int pending();
        return hdr_exp.size() + pl_exp.size() +
               done_exp.size() + trunc_exp;
    endfunction

    task automatic add_short(
        input logic [7:0] di, input logic [7:0] b1,
        input logic [7:0] b2, input logic [7:0] ecc
    );
        burst.push_back(di);
        burst.push_back(b1);
        burst.push_back(b2);
        burst.push_back(ecc);
        hdr_exp.push_back('{di, {b2, b1}, ecc, 1'b0});
        done_exp.push_back('{1'b1, 1'b1});
        exp_pkt = exp_pkt + 1'b1;
    endtask

    task automatic add_long(
        input logic [7:0] di, input bq_t pl, input bit good
    );
        logic [15:0] c;
        logic [15:0] wc;
        c  = crc_model(pl);
        if (!good) c = ~c;
        wc = 16'(pl.size());
        burst.push_back(di);
        burst.push_back(wc[7:0]);
        burst.push_back(wc[15:8]);
        burst.push_back(8'h1A);
        foreach (pl[i]) begin
            burst.push_back(pl[i]);
            pl_exp.push_back('{pl[i], i == pl.size() - 1});
        end
        burst.push_back(c[7:0]);
        burst.push_back(c[15:8]);
        hdr_exp.push_back('{di, wc, 8'h1A, 1'b1});
        done_exp.push_back('{good, 1'b0});
        exp_pkt = exp_pkt + 1'b1;
        if (!good) exp_err = exp_err + 1'b1;
    endtask

    task automatic drive_burst();
        foreach (burst[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = burst[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        burst.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        hdr_t  he;
        pl_t   pe;
        done_t de;
        if (rst_n) begin
            if (hdr_valid) begin
                checks++;
                if (hdr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_extra di=%h", hdr_di);
                end else begin
                    he = hdr_exp.pop_front();
                    if ({hdr_di, hdr_wc, hdr_ecc, hdr_long} !== he) begin
                        errors++;
                        $display("FAIL hdr got %h/%h/%h/%b want %h/%h/%h/%b",
                            hdr_di, hdr_wc, hdr_ecc, hdr_long,
                            he.di, he.wc, he.ecc, he.lng);
                    end
                end
            end
            if (pl_valid) begin
                checks++;
                if (pl_exp.size() == 0) begin
                    errors++;
                    $display("FAIL pl_extra data=%h", pl_data);
                end else begin
                    pe = pl_exp.pop_front();
                    if ({pl_data, pl_last} !== pe) begin
                        errors++;
                        $display("FAIL pl got %h/%b want %h/%b",
                            pl_data, pl_last, pe.d, pe.last);
                    end
                end
            end
            if (pkt_done) begin
                checks++;
                if (done_exp.size() == 0) begin
                    errors++;
                    $display("FAIL done_extra crc_ok=%b", crc_ok);
                end else begin
                    de = done_exp.pop_front();
                    if ({crc_ok, hdr_valid} !== de) begin
                        errors++;
                        $display("FAIL done crc_ok/hdr got %b%b want %b%b",
                            crc_ok, hdr_valid, de.ok, de.with_hdr);
                    end
                end
            end
            if (err_trunc) begin
                checks++;
                if (trunc_exp == 0) begin
                    errors++;
                    $display("FAIL trunc_extra got 1 want 0");
                end else begin
                    trunc_exp--;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        checks++;
        if ({hdr_valid, hdr_di, hdr_wc, hdr_ecc, hdr_long, pl_data,
             pl_valid, pl_last, pkt_done, crc_ok, err_trunc,
             pkt_count, err_count} !== '0) begin
            errors++;
            $display("FAIL reset outputs nonzero, want 0");
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({pkt_count, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0",
                pkt_count, err_count);
        end
    endtask

    task automatic test_lock_ignored();
        burst = '{8'h05, 8'h11, 8'h00, 8'h2C};
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL nolock pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_short();
        @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        add_short(8'h05, 8'h11, 8'h00, 8'h2C);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL short pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_empty_long();
        bq_t none;
        none = {};
        add_long(8'h39, none, 1'b1);
        drive_burst();
        idle(3);
        add_long(8'h39, none, 1'b0);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL empty_long pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_payload();
        bq_t pl;
        pl = '{8'hAA, 8'hBB, 8'hCC};
        add_long(8'h39, pl, 1'b1);
        drive_burst();
        idle(3);
        pl = {};
        for (int i = 0; i < 9; i++) pl.push_back(8'($urandom_range(255)));
        add_long(8'h29, pl, 1'b1);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL payload pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        bq_t none;
        bq_t pl;
        none = {};
        pl   = '{8'h01, 8'h02};
        add_short(8'h05, 8'h11, 8'h00, 8'h2C);
        add_long(8'h39, none, 1'b1);
        add_long(8'h3E, pl, 1'b0);
        add_short(8'h15, 8'h34, 8'h12, 8'h07);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL b2b pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_trunc();
        bq_t pl;
        burst = '{8'h39, 8'h04, 8'h00, 8'h1A, 8'hAA, 8'hBB};
        hdr_exp.push_back('{8'h39, 16'h0004, 8'h1A, 1'b1});
        pl_exp.push_back('{8'hAA, 1'b0});
        pl_exp.push_back('{8'hBB, 1'b0});
        trunc_exp++;
        exp_err = exp_err + 1'b1;
        drive_burst();
        idle(3);
        pl = '{8'h10, 8'h20, 8'h30, 8'h40};
        add_long(8'h39, pl, 1'b1);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL trunc pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_lock_drop();
        bq_t b;
        b = '{8'h39, 8'h08, 8'h00, 8'h1A, 8'h01, 8'h02,
              8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        hdr_exp.push_back('{8'h39, 16'h0008, 8'h1A, 1'b1});
        for (int i = 1; i <= 4; i++) pl_exp.push_back('{8'(i), 1'b0});
        trunc_exp++;
        exp_err = exp_err + 1'b1;
        foreach (b[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b[i];
            if (i == 6) pll_lock = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = 8'h05;
            if (i == 0) pll_lock = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        idle(3);
        add_short(8'h21, 8'h5A, 8'hA5, 8'h3C);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL lockdrop pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_async_reset();
        bq_t b;
        b = '{8'h39, 8'h04, 8'h00, 8'h1A, 8'h11, 8'h22};
        hdr_exp.push_back('{8'h39, 16'h0004, 8'h1A, 1'b1});
        pl_exp.push_back('{8'h11, 1'b0});
        pl_exp.push_back('{8'h22, 1'b0});
        foreach (b[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b[i];
        end
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++;
        if ({hdr_valid, hdr_di, hdr_wc, pl_valid, pkt_done,
             err_trunc, pkt_count, err_count} !== '0 ||
            pending() != 0) begin
            errors++;
            $display("FAIL areset pkt=%0d err=%0d pend=%0d want 0/0/0",
                pkt_count, err_count, pending());
        end
        exp_pkt = '0;
        exp_err = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        add_short(8'h05, 8'h11, 8'h00, 8'h2C);
        drive_burst();
        idle(4);
        checks++;
        if (pending() != 0 || pkt_count !== exp_pkt ||
            err_count !== exp_err) begin
            errors++;
            $display("FAIL post_reset pkt=%0d err=%0d pend=%0d want %0d/%0d/0",
                pkt_count, err_count, pending(), exp_pkt, exp_err);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        trunc_exp = 0;
        exp_pkt   = '0;
        exp_err   = '0;
        test_reset();
        test_lock_ignored();
        test_short();
        test_empty_long();
        test_payload();
        test_back_to_back();
        test_trunc();
        test_lock_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
            checks, errors);
        $finish;
    end

endmodule
